inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Pipelined RV32I instruction encoder: packs decoded fields (format, opcode, rd/rs1/rs2, funct3/funct7, 32-bit signed immediate) into a 32-bit instruction word.
- This is the inverse of the core's immediate generator; it scatters the immediate into the format-specific bit positions.
- Used by the boot/program loader and by the verification environment to write instruction memory.
- Word-sequential write addresses come from an internal counter.

Parameters:
- BASE_ADDR, 32'h0000_0000, first instruction-memory byte address emitted.
- DEPTH, 256, instruction-memory size in words; address wraps after DEPTH words. Must be ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input fields valid.
- in_ready  out  1  encoder accepts input this cycle.
- in_fmt  in  3  fmt_e: R, I, S, B, U, J, SH (shift-immediate).
- in_opcode  in  7  opcode field.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field (R, SH).
- in_imm  in  32  signed immediate, byte offset for B/J, full value for U.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts the word.
- out_inst  out  32  encoded instruction.
- out_addr  out  32  byte address for out_inst.
- out_err  out  1  immediate or format error on this word.

Behaviour:
- Reset: out_valid=0, in_ready=1, out_inst=0, out_addr=BASE_ADDR, out_err=0, all pipeline valids cleared. Reset asserted mid-stream discards in-flight words; the address counter restarts at BASE_ADDR.
- Pipeline, 2 stages:
  - S1 registers the fields and computes the range check.
  - S2 registers the assembled word, which drives out_inst.
  - Latency 2 cycles from accept (in_valid&&in_ready) to out_valid when not stalled.
  - Throughput 1 word per cycle.
- Handshake:
  - A stage loads when it is empty or its content moves downstream the same cycle.
  - in_ready = !s1_valid || s2 can load. in_ready is combinational from out_ready through one stage (no skid).
  - Outputs hold stable while out_valid && !out_ready.
- Encoding (standard RV32I):
  - R: f7|rs2|rs1|f3|rd|op.
  - I: imm[11:0]|rs1|f3|rd|op.
  - SH: f7|imm[4:0]|rs1|f3|rd|op.
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op.
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
  - U: imm[31:12]|rd|op.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
  - Unused fields are ignored.
- Range rules (macro-dependent, see Optional Feature):
  - I/S: -2048..2047.
  - B: -4096..4094, imm[0]=0.
  - J: -2^20..2^20-2, imm[0]=0.
  - U: imm[11:0]=0.
  - SH: imm[31:5]=0.
  - Reserved fmt value 7 always yields NOP 32'h0000_0013.
- Address:
  - out_addr advances by 4 on each out_valid&&out_ready, including error words.
  - After DEPTH words it returns to BASE_ADDR.
  - DEPTH=1 keeps it constant.

Optional Feature:
- INST_ENC_RANGE_CHK_EN defined:
  - A word violating a range rule, or with reserved fmt, is emitted as NOP 32'h0000_0013 with out_err=1.
  - It still consumes an address.
- Undefined:
  - No checks; immediates are silently truncated to the field bits.
  - Reserved fmt still emits NOP.
  - out_err tied 0.

Decomposition:
- Package inst_enc_pkg holds:
  - typedef fmt_e.
  - Opcode constants OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_REG.
  - NOP_INST=32'h0000_0013.
  - Range-limit constants.
- One sub-module, inst_enc_pack: combinational field packer (fmt + fields → word). It is instantiated in S2; the handshake and counter live in the top.

Test Plan:
- I addi: fmt=I, op=7'b0010011, rd=1, rs1=0, f3=0, imm=5 → out_inst=32'h0050_0093, out_addr=0, out_valid 2 cycles after accept.
- S/B: sw with rs1=1, rs2=2, f3=3'b010, imm=8 → 32'h0020_A423; beq with rs1=rs2=0, imm=-8 → 32'hFE00_0CE3.
- J: jal rd=1, imm=2048 → 32'h0010_00EF; misaligned imm=2049 with macro → 32'h0000_0013, out_err=1.
- Range: addi rd=1, imm=2048 → with macro NOP and out_err=1; without macro 32'h8000_0093 and out_err=0.
- Backpressure/wrap: DEPTH=4, out_ready low 3 cycles while in_valid is held high:
  - in_ready drops after 2 accepts, with no loss or reorder.
  - Then 5 words emit addresses 0, 4, 8, 12, 0.
- Reset mid-stream: rst_n low with 2 words in flight → out_valid=0 immediately, next word after release at addr BASE_ADDR.

Source files
------------

// File: rtl/inst_enc_pkg.sv
// Shared types, opcode constants and immediate range limits for the RV32I instruction encoder.
package inst_enc_pkg;

  localparam int unsigned INST_W  = 32;
  localparam int unsigned OPC_W   = 7;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned F3_W    = 3;
  localparam int unsigned F7_W    = 7;
  localparam int unsigned FMT_W   = 3;
  localparam int unsigned ADDR_W  = 32;

  typedef enum logic [FMT_W-1:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SH   = 3'd6,
    FMT_RSVD = 3'd7
  } fmt_e;

  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OP_REG    = 7'b0110011;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;
  localparam int IMM_J_MIN = -(1 << 20);
  localparam int IMM_J_MAX = (1 << 20) - 2;

  typedef struct packed {
    fmt_e              fmt;
    logic [OPC_W-1:0]  opcode;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [F3_W-1:0]   funct3;
    logic [F7_W-1:0]   funct7;
    logic [INST_W-1:0] imm;
  } fields_t;

  // True when the immediate fits the target field of its format exactly.
  function automatic logic imm_ok(input fmt_e fmt, input logic [INST_W-1:0] imm);
    int   simm;
    logic ok;
    simm = int'($signed(imm));
    ok   = 1'b0;
    case (fmt)
      FMT_R:        ok = 1'b1;
      FMT_I, FMT_S: ok = (simm >= IMM12_MIN) && (simm <= IMM12_MAX);
      FMT_B:        ok = (simm >= IMM_B_MIN) && (simm <= IMM_B_MAX) && !imm[0];
      FMT_U:        ok = (imm[11:0] == 12'd0);
      FMT_J:        ok = (simm >= IMM_J_MIN) && (simm <= IMM_J_MAX) && !imm[0];
      FMT_SH:       ok = (imm[31:5] == 27'd0);
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/inst_enc_pack.sv
// Combinational field packer: scatters decoded fields into a 32-bit RV32I word.
module inst_enc_pack
  import inst_enc_pkg::*;
(
  input  fields_t            fields,
  output logic [INST_W-1:0]  inst_c
);

  always_comb begin
    inst_c = NOP_INST;
    case (fields.fmt)
      FMT_R:  inst_c = {fields.funct7, fields.rs2, fields.rs1, fields.funct3,
                        fields.rd, fields.opcode};
      FMT_I:  inst_c = {fields.imm[11:0], fields.rs1, fields.funct3,
                        fields.rd, fields.opcode};
      FMT_SH: inst_c = {fields.funct7, fields.imm[4:0], fields.rs1, fields.funct3,
                        fields.rd, fields.opcode};
      FMT_S:  inst_c = {fields.imm[11:5], fields.rs2, fields.rs1, fields.funct3,
                        fields.imm[4:0], fields.opcode};
      FMT_B:  inst_c = {fields.imm[12], fields.imm[10:5], fields.rs2, fields.rs1,
                        fields.funct3, fields.imm[4:1], fields.imm[11], fields.opcode};
      FMT_U:  inst_c = {fields.imm[31:12], fields.rd, fields.opcode};
      FMT_J:  inst_c = {fields.imm[20], fields.imm[10:1], fields.imm[11],
                        fields.imm[19:12], fields.rd, fields.opcode};
      default: inst_c = NOP_INST;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage RV32I instruction encoder with word-sequential address counter.
// Define INST_ENC_RANGE_CHK_EN to replace out-of-range words with a flagged NOP.
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned       DEPTH     = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FMT_W-1:0]    in_fmt,
  input  logic [OPC_W-1:0]    in_opcode,
  input  logic [REG_W-1:0]    in_rd,
  input  logic [REG_W-1:0]    in_rs1,
  input  logic [REG_W-1:0]    in_rs2,
  input  logic [F3_W-1:0]     in_funct3,
  input  logic [F7_W-1:0]     in_funct7,
  input  logic [INST_W-1:0]   in_imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INST_W-1:0]   out_inst,
  output logic [ADDR_W-1:0]   out_addr,
  output logic                out_err
);

  localparam int unsigned      IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

  fields_t             s1_q, s1_d;
  logic                s1_valid_q, s1_valid_d;
  logic                s1_err_q, s1_err_d;
  logic                s2_valid_q, s2_valid_d;
  logic [INST_W-1:0]   s2_inst_q, s2_inst_d;
  logic                s2_err_q, s2_err_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [INST_W-1:0]   pack_inst;
  logic                s1_load, s2_load, emit;
  fields_t             in_fields;

  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;
  assign emit     = s2_valid_q && out_ready;

  assign in_fields = '{fmt: fmt_e'(in_fmt), opcode: in_opcode, rd: in_rd, rs1: in_rs1,
                       rs2: in_rs2, funct3: in_funct3, funct7: in_funct7, imm: in_imm};

  inst_enc_pack u_pack (
    .fields (s1_q),
    .inst_c (pack_inst)
  );

  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    s1_err_d   = s1_err_q;
    s2_valid_d = s2_valid_q;
    s2_inst_d  = s2_inst_q;
    s2_err_d   = s2_err_q;
    idx_d      = idx_q;
    addr_d     = addr_q;

    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d = in_fields;
`ifdef INST_ENC_RANGE_CHK_EN
        s1_err_d = !imm_ok(in_fields.fmt, in_imm);
`else
        s1_err_d = 1'b0;
`endif
      end
    end

    // Flagged words are forced to NOP so the loader never writes a truncated immediate.
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_inst_d = s1_err_q ? NOP_INST : pack_inst;
        s2_err_d  = s1_err_q;
      end
    end

    if (emit) begin
      if (idx_q == IDX_LAST) begin
        idx_d  = '0;
        addr_d = BASE_ADDR;
      end else begin
        idx_d  = idx_q + IDX_W'(1);
        addr_d = addr_q + ADDR_W'(4);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_inst_q  <= '0;
      s2_err_q   <= 1'b0;
      idx_q      <= '0;
      addr_q     <= BASE_ADDR;
    end else begin
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      s1_err_q   <= s1_err_d;
      s2_valid_q <= s2_valid_d;
      s2_inst_q  <= s2_inst_d;
      s2_err_q   <= s2_err_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_inst  = s2_inst_q;
  assign out_addr  = addr_q;
  assign out_err   = s2_err_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder (DEPTH=4); expectations follow INST_ENC_RANGE_CHK_EN.
module tb_inst_encoder;
  import inst_enc_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef INST_ENC_RANGE_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        out_err;

  inst_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_addr  (out_addr),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] exp_addr;
  int          n_checks;
  int          n_errors;
  bit          rnd_done;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference encoder built from shifts and masks.
  function automatic logic [31:0] ref_encode(input logic [2:0] fmt, input logic [6:0] op,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    logic [31:0] base;
    base = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
    case (fmt)
      3'd0: return base | (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rd) << 7);
      3'd1: return base | ((imm & 32'hFFF) << 20) | (32'(rd) << 7);
      3'd2: return base | (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | ((imm & 32'h1F) << 7);
      3'd3: return base | (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                 | (32'(rs2) << 20) | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
      3'd4: return (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'(op);
      3'd5: return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                 | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                 | (32'(rd) << 7) | 32'(op);
      3'd6: return base | (32'(f7) << 25) | ((imm & 32'h1F) << 20) | (32'(rd) << 7);
      default: return 32'h0000_0013;
    endcase
  endfunction

  function automatic logic ref_err(input logic [2:0] fmt, input logic [31:0] imm);
    longint s;
    s = longint'($signed(imm));
    case (fmt)
      3'd1, 3'd2: return (s < -2048) || (s > 2047);
      3'd3:       return (s < -4096) || (s > 4094) || imm[0];
      3'd4:       return imm[11:0] != 12'd0;
      3'd5:       return (s < -1048576) || (s > 1048574) || imm[0];
      3'd6:       return imm[31:5] != 27'd0;
      3'd7:       return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
  endtask

  // Present one word, wait (bounded) for acceptance and record its expected result.
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm,
      input logic [31:0] exp_inst, input logic exp_err);
    int waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    drive(fmt, op, rd, rs1, rs2, f3, f7, imm);
    #1;
    while (!in_ready && waited < 50) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      check_eq("in_ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      e.inst = exp_inst;
      e.err  = exp_err;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm);
    logic e;
    e = CHK ? ref_err(fmt, imm) : 1'b0;
    send(fmt, op, rd, rs1, rs2, f3, f7, imm,
         e ? 32'h0000_0013 : ref_encode(fmt, op, rd, rs1, rs2, f3, f7, imm), e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    exp_addr = BASE;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor: compare every transferred word against the scoreboard and address model.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (rst_n && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_word", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          check_eq("inst", out_inst, e.inst);
          check_eq("err", 32'(out_err), 32'(e.err));
          check_eq("addr", out_addr, exp_addr);
          exp_addr = (exp_addr == BASE + 32'(4 * (DEPTH - 1))) ? BASE : exp_addr + 32'd4;
        end
      end
    end
  end

  initial begin
    int          acc;
    logic        last_rdy;
    logic [2:0]  rf;
    logic [31:0] rimm;
    exp_t        e;

    n_checks = 0; n_errors = 0; rnd_done = 1'b0;
    exp_addr = BASE;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b0;
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_inst", out_inst, 32'd0);
    check_eq("rst_out_addr", out_addr, BASE);
    check_eq("rst_out_err", 32'(out_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Latency: addi x1, x0, 5 appears two cycles after acceptance.
    send(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
    check_eq("lat_cycle1_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check_eq("lat_cycle2_valid", 32'(out_valid), 32'd1);
    check_eq("lat_cycle2_addr", out_addr, BASE);

    send(FMT_S, OP_STORE, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 32'h0020_A423, 1'b0);
    send(FMT_B, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd8, 32'hFE00_0CE3, 1'b0);
    send(FMT_J, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0010_00EF, 1'b0);
    send(FMT_J, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2049,
         CHK ? 32'h0000_0013 : 32'h0010_00EF, CHK);
    send(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,
         CHK ? 32'h0000_0013 : 32'h8000_0093, CHK);
    send(3'd7, OP_REG, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h0000_0013, CHK);
    send(FMT_U, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    send(FMT_SH, OP_IMM, 5'd3, 5'd3, 5'd0, 3'd1, 7'd0, 32'd7, 32'h0071_9193, 1'b0);
    send(FMT_R, OP_REG, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0, 32'h4020_81B3, 1'b0);
    send(FMT_U, OP_LUI, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1001,
         CHK ? 32'h0000_0013 : 32'h0000_1037, CHK);
    drain("drain_directed");

    // Random words under random backpressure.
    fork
      begin
        while (!rnd_done) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 40; i++) begin
          rf = 3'($urandom_range(0, 7));
          case ($urandom_range(0, 3))
            0: rimm = $urandom;
            1: rimm = {{20{rimm[11]}}, 12'($urandom)};
            2: begin rimm = 32'($urandom); rimm = {{19{rimm[12]}}, rimm[12:1], 1'b0}; end
            default: rimm = 32'($urandom_range(0, 31));
          endcase
          send_model(rf, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                     3'($urandom), 7'($urandom), rimm);
        end
        rnd_done = 1'b1;
      end
    join
    drain("drain_random");

    // Backpressure and address wrap from a fresh reset.
    do_reset();
    @(negedge clk);
    out_ready = 1'b0;
    acc = 0;
    last_rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      drive(FMT_I, OP_IMM, 5'(acc + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(acc + 1));
      #1;
      last_rdy = in_ready;
      if (in_ready) begin
        e.inst = ref_encode(FMT_I, OP_IMM, 5'(acc + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(acc + 1));
        e.err  = 1'b0;
        sb_q.push_back(e);
        acc++;
      end
    end
    check_eq("bp_accepts", 32'(acc), 32'd2);
    check_eq("bp_in_ready_low", 32'(last_rdy), 32'd0);
    check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
    check_eq("bp_hold_inst", out_inst, 32'h0010_0093);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check_eq("bp_resume_ready", 32'(in_ready), 32'd1);
    if (in_ready) begin
      e.inst = ref_encode(FMT_I, OP_IMM, 5'(acc + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(acc + 1));
      e.err  = 1'b0;
      sb_q.push_back(e);
      acc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    send_model(FMT_I, OP_IMM, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4);
    send_model(FMT_I, OP_IMM, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    drain("drain_wrap");
    check_eq("wrap_addr_after5", out_addr, BASE + 32'd4);

    // Reset with two words in flight discards them and restarts the address.
    @(negedge clk);
    out_ready = 1'b0;
    send_model(FMT_R, OP_REG, 5'd7, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    send_model(FMT_R, OP_REG, 5'd8, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_out_addr", out_addr, BASE);
    check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
    sb_q.delete();
    exp_addr = BASE;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(FMT_S, OP_STORE, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 32'h0020_A423, 1'b0);
    drain("drain_midrst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
